wshb_arbiter: RTL and testbench
===============================

WSHB_ARBITER -- requirements
Module: wshb_arbiter

Interface
REQ-001 Parameter NM, default 2: number of Wishbone classic masters; index 0 = VGA framebuffer reader, 1 = test-pattern (mire) writer.
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter DW, default 32: data width; select width is DW/8.
REQ-004 Parameter MAX_HOLD, default 64: acknowledged transfers before forced hand-over; 0 disables pre-emption.
REQ-005 clk  in  1  single clock for the whole block; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 m_cyc  in  [NM-1:0]  per-master cycle request.
REQ-008 m_stb  in  [NM-1:0]  per-master strobe.
REQ-009 m_we  in  [NM-1:0]  per-master write enable.
REQ-010 m_adr  in  [NM-1:0][AW-1:0]  per-master address.
REQ-011 m_dat_w  in  [NM-1:0][DW-1:0]  per-master write data.
REQ-012 m_sel  in  [NM-1:0][DW/8-1:0]  per-master byte select.
REQ-013 m_ack  out  [NM-1:0]  per-master acknowledge.
REQ-014 m_dat_r  out  DW  read data, broadcast to all masters.
REQ-015 s_cyc, s_stb, s_we  out  1 each  slave (SDRAM controller) cycle, strobe, write enable.
REQ-016 s_adr  out  AW / s_dat_w  out  DW / s_sel  out  DW/8  slave address, write data, byte select.
REQ-017 s_ack  in  1 / s_dat_r  in  DW  slave acknowledge and read data.
REQ-018 grant  out  [NM-1:0]  registered one-hot owner; all-zero when no owner.

Function
REQ-019 FSM states: IDLE, OWN, SWITCH.
REQ-020 IDLE: if any m_cyc is high, the next owner is chosen round-robin starting at (last+1) mod NM; grant loads it and state goes to OWN at the next edge; otherwise the FSM stays in IDLE.
REQ-021 Grant latency: m_cyc rising in cycle t while IDLE gives grant and slave forwarding from cycle t+1.
REQ-022 OWN: s_cyc, s_stb, s_we, s_adr, s_dat_w and s_sel equal the owner's signals combinationally; m_ack[i] = s_ack & grant[i]; the other m_ack bits are 0.
REQ-023 When grant is zero or the state is SWITCH, s_cyc, s_stb, s_we, s_adr, s_dat_w and s_sel are 0.
REQ-024 m_dat_r = s_dat_r at all times.
REQ-025 OWN, owner drops m_cyc: last = owner, grant clears and the state goes to IDLE at the next edge; the slave sees cyc=0 that same cycle.
REQ-026 Hold counter, width $clog2(MAX_HOLD+1): cleared on entering OWN; incremented on each forwarded s_ack; saturates at MAX_HOLD.
REQ-027 Pre-emption: in OWN with MAX_HOLD>0, an s_ack that brings the count to MAX_HOLD while another m_cyc is high triggers the hand-over. At the next edge: state goes to SWITCH, last = owner, grant clears.
REQ-028 SWITCH lasts exactly one cycle with slave outputs zero. The next owner is then picked as in IDLE, excluding no master, and the state goes to OWN.
REQ-029 A pre-empted master keeps its stb; the transfer resumes when that master is next granted.
REQ-030 A transfer in flight (s_stb high, s_ack not yet seen) is never cut; pre-emption takes effect only on an ack edge.
REQ-031 If the count reaches MAX_HOLD with no other requester, the owner keeps the grant. Pre-emption fires on the first ack after another master raises m_cyc.
REQ-032 Simultaneous requests after reset: master 0 wins.
REQ-033 m_stb without m_cyc is ignored.

Reset
REQ-034 rst_n low at an edge forces the following, even mid-transfer: state IDLE, grant 0, counter 0, last = NM-1.
REQ-035 Consequently, from the first edge with rst_n low, all s_* outputs and m_ack are 0.

Structure
REQ-036 Package wshb_arb_pkg holds the state enum and the default values of NM, AW, DW and MAX_HOLD.
REQ-037 Sub-module rr_pick (combinational): inputs are the request vector and last; output is the one-hot next owner, all-zero when there are no requests.

Verification
REQ-038 Single master: m_cyc[1]=1 at cycle 10 → grant=2'b10 and s_cyc=1 from cycle 11; 4 slave acks → m_ack[1] pulses 4 times, m_ack[0]=0.
REQ-039 Simultaneous requests right after reset → grant=2'b01 first; when master 0 drops cyc → IDLE one cycle, then grant=2'b10.
REQ-040 MAX_HOLD=4, both masters streaming → 4th ack to master 0, then one SWITCH cycle with s_cyc=0, then grant=2'b10; ack ownership alternates in groups of 4.
REQ-041 MAX_HOLD=4, only master 0 requests for 10 acks → no SWITCH, grant stays 2'b01; master 1 raises cyc → hand-over on the next ack.
REQ-042 rst_n low while s_stb=1 for master 1 → from that edge s_cyc=0, grant=0; after release the first requester is granted normally.
REQ-043 Read data check: slave returns 0xDEADBEEF with ack → m_dat_r=0xDEADBEEF and only the owner's m_ack is high.

Source files
------------

// File: rtl/wshb_arbiter_pkg.sv
// wshb_arb_pkg: shared FSM state type and default parameters for the Wishbone arbiter.
package wshb_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN, SWITCH} arb_state_e;
  localparam int NM_DEF = 2;
  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;
  localparam int MAX_HOLD_DEF = 64;
endpackage

// File: rtl/wshb_arbiter_if.sv
// wshb_arbiter_if: master-side and slave-side Wishbone classic signals around the arbiter.
interface wshb_arbiter_if
  import wshb_arb_pkg::*;
#(
  parameter int NM = NM_DEF,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();
  logic [NM-1:0] m_cyc;
  logic [NM-1:0] m_stb;
  logic [NM-1:0] m_we;
  logic [NM-1:0][AW-1:0] m_adr;
  logic [NM-1:0][DW-1:0] m_dat_w;
  logic [NM-1:0][DW/8-1:0] m_sel;
  logic [NM-1:0] m_ack;
  logic [DW-1:0] m_dat_r;
  logic s_cyc;
  logic s_stb;
  logic s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_w;
  logic [DW/8-1:0] s_sel;
  logic s_ack;
  logic [DW-1:0] s_dat_r;
  logic [NM-1:0] grant;
  modport slave (
    input m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel, s_ack, s_dat_r,
    output m_ack, m_dat_r, s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel, grant
  );
  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel, s_ack, s_dat_r,
    input m_ack, m_dat_r, s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel, grant
  );
endinterface

// File: rtl/wshb_arbiter_rr_pick.sv
// rr_pick: one-hot round-robin choice among requests, searching from last+1 upward.
module rr_pick #(
  parameter int NM = 2,
  parameter int LW = 1
) (
  input  logic [NM-1:0] req,
  input  logic [LW-1:0] last,
  output logic [NM-1:0] pick
);
  // walk from farthest to nearest so the nearest requester overwrites
  always_comb begin
    pick = '0;
    for (int k = NM; k > 0; k--)
      if (req[(int'(last) + k) % NM]) pick = NM'(1) << ((int'(last) + k) % NM);
  end
endmodule

// File: rtl/wshb_arbiter.sv
// wshb_arbiter: round-robin Wishbone classic arbiter with ack-count pre-emption.
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int NM = NM_DEF,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input logic clk,
  input logic rst_n,
  wshb_arbiter_if.slave bus
);
  localparam int LW = NM > 1 ? $clog2(NM) : 1;
  localparam int CW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;
  arb_state_e state;
  logic [NM-1:0] grant, pick;
  logic [LW-1:0] last, own_idx;
  logic [CW-1:0] cnt, cnt_nxt;
  logic owned, own_cyc, fwd_ack, preempt;
  rr_pick #(.NM(NM), .LW(LW)) u_pick (.req(bus.m_cyc), .last(last), .pick(pick));
  always_comb begin
    own_idx = '0;
    for (int i = 0; i < NM; i++) own_idx = grant[i] ? LW'(i) : own_idx;
  end
  assign owned   = state == OWN && |grant;
  assign own_cyc = |(bus.m_cyc & grant);
  assign fwd_ack = owned & bus.s_ack;
  assign cnt_nxt = cnt == CW'(MAX_HOLD) ? cnt : cnt + CW'(1);
  // hand-over only on an ack edge, so an in-flight transfer is never cut
  assign preempt = MAX_HOLD > 0 && fwd_ack && cnt_nxt == CW'(MAX_HOLD) && |(bus.m_cyc & ~grant);
  assign bus.s_cyc   = owned & bus.m_cyc[own_idx];
  assign bus.s_stb   = owned & bus.m_stb[own_idx];
  assign bus.s_we    = owned & bus.m_we[own_idx];
  assign bus.s_adr   = owned ? bus.m_adr[own_idx] : {AW{1'b0}};
  assign bus.s_dat_w = owned ? bus.m_dat_w[own_idx] : {DW{1'b0}};
  assign bus.s_sel   = owned ? bus.m_sel[own_idx] : {(DW/8){1'b0}};
  assign bus.m_ack   = {NM{fwd_ack}} & grant;
  assign bus.m_dat_r = bus.s_dat_r;
  assign bus.grant   = grant;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      cnt   <= '0;
      last  <= LW'(NM - 1);
    end else
      case (state)
        OWN:
          if (!own_cyc || preempt) begin
            state <= own_cyc ? SWITCH : IDLE;
            grant <= '0;
            last  <= own_idx;
          end else if (fwd_ack) cnt <= cnt_nxt;
        default: begin
          state <= |bus.m_cyc ? OWN : IDLE;
          grant <= pick;
          cnt   <= '0;
        end
      endcase
endmodule

// File: tb/tb_wshb_arbiter.sv
// tb_wshb_arbiter: scoreboard bench driving two masters and a zero-wait slave model.
module tb_wshb_arbiter;
  localparam int NM = 2, AW = 32, DW = 32;
  typedef struct {int owner; logic [31:0] data;} exp_t;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  wshb_arbiter_if #(.NM(NM), .AW(AW), .DW(DW)) bus ();
  wshb_arbiter #(.NM(NM), .AW(AW), .DW(DW), .MAX_HOLD(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0, obs = 0, ack0 = 0, ack1 = 0, ex;
  bit ack_en = 0, use_beef = 0;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // slave answers in the cycle it sees stb; expectation is queued then checked on m_ack
  task automatic tick();
    exp_t e;
    #1;
    bus.s_ack = ack_en && bus.s_cyc && bus.s_stb;
    bus.s_dat_r = use_beef ? 32'hDEADBEEF : bus.s_adr ^ 32'h5A5A5A5A;
    if (bus.s_ack) sb.push_back('{int'(bus.s_adr[31:28]), bus.s_dat_r});
    #1;
    obs = bus.m_ack == 2'b01 ? 0 : bus.m_ack == 2'b10 ? 1 : bus.m_ack == 2'b00 ? 2 : 3;
    if (obs == 0) ack0++;
    if (obs == 1) ack1++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("ack_owner", bus.m_ack, 64'(2'b01 << e.owner));
      check("dat_r", bus.m_dat_r, e.data);
    end else check("no_ack", bus.m_ack, 0);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask
  task automatic rst_seq();
    rst_n = 0;
    bus.m_cyc = '0;
    bus.m_stb = '0;
    ack_en = 0;
    use_beef = 0;
    tick();
    check("rst_grant", bus.grant, 0);
    check("rst_scyc", bus.s_cyc, 0);
    rst_n = 1;
  endtask
  initial begin
    bus.m_cyc = '0;
    bus.m_stb = '0;
    bus.m_we = 2'b10;
    bus.m_adr[0] = 32'h0000_1000;
    bus.m_adr[1] = 32'h1000_2000;
    bus.m_dat_w[0] = 32'h1111_0000;
    bus.m_dat_w[1] = 32'h2222_0000;
    bus.m_sel[0] = 4'hF;
    bus.m_sel[1] = 4'h3;
    bus.s_ack = 0;
    bus.s_dat_r = '0;
    @(posedge clk);
    @(negedge clk);
    rst_seq();
    // single master, request at cycle 10
    while (cyc < 10) tick();
    bus.m_cyc[1] = 1;
    bus.m_stb[1] = 1;
    #1 check("lat_scyc_t", bus.s_cyc, 0);
    tick();
    check("s1_grant", bus.grant, 2'b10);
    check("s1_scyc", bus.s_cyc, 1);
    check("s1_sadr", bus.s_adr, 32'h1000_2000);
    check("s1_sdatw", bus.s_dat_w, 32'h2222_0000);
    check("s1_ssel", bus.s_sel, 4'h3);
    check("s1_swe", bus.s_we, 1);
    ack0 = 0;
    ack1 = 0;
    ack_en = 1;
    repeat (4) tick();
    ack_en = 0;
    check("s1_ack1", ack1, 4);
    check("s1_ack0", ack0, 0);
    bus.m_cyc[1] = 0;
    bus.m_stb[1] = 0;
    #1 check("s1_drop_scyc", bus.s_cyc, 0);
    tick();
    check("s1_release", bus.grant, 0);
    // simultaneous requests after reset
    rst_seq();
    bus.m_cyc = 2'b11;
    bus.m_stb = 2'b11;
    tick();
    check("s2_first", bus.grant, 2'b01);
    ack_en = 1;
    repeat (2) tick();
    ack_en = 0;
    bus.m_cyc[0] = 0;
    bus.m_stb[0] = 0;
    #1 check("s2_drop_scyc", bus.s_cyc, 0);
    tick();
    check("s2_idle", bus.grant, 0);
    tick();
    check("s2_second", bus.grant, 2'b10);
    // both streaming: groups of 4 acks split by one switch cycle
    rst_seq();
    bus.m_cyc = 2'b11;
    bus.m_stb = 2'b11;
    ack_en = 1;
    tick();
    for (int j = 1; j <= 20; j++) begin
      tick();
      ex = (j - 1) % 5 == 4 ? 2 : ((j - 1) / 5) % 2;
      check("rr_pattern", obs, ex);
    end
    // lone master saturates, then hands over on next ack once master 1 asks
    rst_seq();
    bus.m_cyc = 2'b01;
    bus.m_stb = 2'b01;
    ack_en = 1;
    tick();
    for (int j = 0; j < 10; j++) begin
      tick();
      check("s4_owner", obs, 0);
      check("s4_grant", bus.grant, 2'b01);
    end
    bus.m_cyc[1] = 1;
    bus.m_stb[1] = 1;
    tick();
    check("s4_lastack", obs, 0);
    check("s4_switch", bus.grant, 0);
    tick();
    check("s4_sw_noack", obs, 2);
    check("s4_new", bus.grant, 2'b10);
    tick();
    check("s4_new_ack", obs, 1);
    // reset mid-transfer
    rst_seq();
    bus.m_cyc = 2'b10;
    bus.m_stb = 2'b10;
    tick();
    check("s5_grant", bus.grant, 2'b10);
    check("s5_stb", bus.s_stb, 1);
    rst_n = 0;
    tick();
    check("s5_rst_scyc", bus.s_cyc, 0);
    check("s5_rst_sstb", bus.s_stb, 0);
    check("s5_rst_grant", bus.grant, 0);
    rst_n = 1;
    tick();
    check("s5_regrant", bus.grant, 2'b10);
    // read data broadcast
    use_beef = 1;
    ack_en = 1;
    tick();
    check("beef_dat", bus.m_dat_r, 32'hDEADBEEF);
    check("beef_ack", bus.m_ack, 2'b10);
    // stb without cyc
    rst_seq();
    bus.m_stb = 2'b01;
    repeat (2) tick();
    check("stb_only_grant", bus.grant, 0);
    check("stb_only_sstb", bus.s_stb, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
